// File: rtl/cpu_io_bridge.sv
// Device-side byte port endpoint: host->CPU input FIFO and CPU->host output FIFO with sticky error status.
// Optional macro IO_LOOPBACK_EN adds lb_en, which routes output FIFO bytes back into the input FIFO.
module cpu_io_bridge #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] cpu_data_in,
    input  logic        cpu_in_rd,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_out_wr,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    input  logic        err_clr
`ifdef IO_LOOPBACK_EN
    ,
    input  logic        lb_en
`endif
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [7:0]    in_mem  [DEPTH];
    logic [7:0]    out_mem [DEPTH];
    logic [AW-1:0] in_wp, in_rp, out_wp, out_rp;
    logic [AW:0]   in_cnt, out_cnt;
    logic          in_uflow, out_oflow;

    logic          in_empty, in_full, out_empty, out_full;
    logic          in_push, in_pop, out_push, out_pop, lb_push;
    logic [7:0]    in_wdata, in_head, out_head;

    assign in_empty  = (in_cnt == '0);
    assign in_full   = (in_cnt == FULL_CNT);
    assign out_empty = (out_cnt == '0);
    assign out_full  = (out_cnt == FULL_CNT);

    assign in_head  = in_empty  ? 8'h00 : in_mem[in_rp];
    assign out_head = out_empty ? 8'h00 : out_mem[out_rp];

    // Loopback steals the input FIFO slot from the host and hides the output stream.
`ifdef IO_LOOPBACK_EN
    assign lb_push = lb_en & ~out_empty & ~in_full;
    assign m_valid = ~out_empty & ~lb_en;
`else
    assign lb_push = 1'b0;
    assign m_valid = ~out_empty;
`endif

    assign s_ready  = ~in_full & ~lb_push;
    assign in_push  = lb_push | (s_valid & s_ready);
    assign in_wdata = lb_push ? out_head : s_data;
    assign in_pop   = cpu_in_rd & ~in_empty;

    // A same-cycle pop frees the slot, so a write into a full FIFO still lands.
    assign out_pop  = lb_push | (m_valid & m_ready);
    assign out_push = cpu_out_wr & (~out_full | out_pop);

    assign m_data      = out_head;
    assign cpu_data_in = {16'h0000, 4'(in_cnt), out_oflow, in_uflow, out_full, ~in_empty, in_head};

    always_ff @(posedge clk) begin
        if (in_push) in_mem[in_wp] <= in_wdata;
        if (out_push) out_mem[out_wp] <= cpu_data_out;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_wp     <= '0;
            in_rp     <= '0;
            in_cnt    <= '0;
            out_wp    <= '0;
            out_rp    <= '0;
            out_cnt   <= '0;
            in_uflow  <= 1'b0;
            out_oflow <= 1'b0;
        end else begin
            if (in_push) in_wp <= in_wp + PTR_ONE;
            if (in_pop) in_rp <= in_rp + PTR_ONE;
            in_cnt <= in_cnt + {{AW{1'b0}}, in_push} - {{AW{1'b0}}, in_pop};

            if (out_push) out_wp <= out_wp + PTR_ONE;
            if (out_pop) out_rp <= out_rp + PTR_ONE;
            out_cnt <= out_cnt + {{AW{1'b0}}, out_push} - {{AW{1'b0}}, out_pop};

            // Setting an error wins over clearing it in the same cycle.
            if (cpu_in_rd & in_empty) in_uflow <= 1'b1;
            else if (err_clr) in_uflow <= 1'b0;

            if (cpu_out_wr & out_full & ~out_pop) out_oflow <= 1'b1;
            else if (err_clr) out_oflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Bench for cpu_io_bridge: queue-based reference model checked every cycle, plus directed literal checks.
module tb_cpu_io_bridge;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] cpu_data_in;
    logic        cpu_in_rd = 1'b0;
    logic [7:0]  cpu_data_out = 8'h00;
    logic        cpu_out_wr = 1'b0;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic        lb_en = 1'b0;

    int checks = 0;
    int errors = 0;

    cpu_io_bridge #(.DEPTH(DEPTH), .AW(3)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .cpu_data_in(cpu_data_in), .cpu_in_rd(cpu_in_rd),
        .cpu_data_out(cpu_data_out), .cpu_out_wr(cpu_out_wr),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .err_clr(err_clr)
`ifdef IO_LOOPBACK_EN
        , .lb_en(lb_en)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: two byte queues and two sticky flags.
    logic [7:0] inq[$];
    logic [7:0] outq[$];
    bit uf = 0;
    bit of = 0;

    function automatic bit lb_active();
`ifdef IO_LOOPBACK_EN
        return lb_en;
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge rst) begin
        inq.delete();
        outq.delete();
        uf = 0;
        of = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            int  n_in, n_out;
            bit  lb, host_push, pop_in, pop_out, push_out;
            logic [7:0] lb_byte;
            n_in  = inq.size();
            n_out = outq.size();
            lb = lb_active() && n_out > 0 && n_in < DEPTH;
            host_push = s_valid && n_in < DEPTH && !lb;
            pop_in = cpu_in_rd && n_in > 0;
            pop_out = lb || (n_out > 0 && !lb_active() && m_ready);
            push_out = cpu_out_wr && (n_out < DEPTH || pop_out);
            lb_byte = (n_out > 0) ? outq[0] : 8'h00;
            if (cpu_in_rd && n_in == 0) uf = 1;
            else if (err_clr) uf = 0;
            if (cpu_out_wr && n_out == DEPTH && !pop_out) of = 1;
            else if (err_clr) of = 0;
            if (pop_in) void'(inq.pop_front());
            if (pop_out) void'(outq.pop_front());
            if (lb) inq.push_back(lb_byte);
            else if (host_push) inq.push_back(s_data);
            if (push_out) outq.push_back(cpu_data_out);
        end
    end

    function automatic logic [31:0] exp_status();
        int v;
        v = (inq.size() > 0) ? int'(inq[0]) : 0;
        v += (inq.size() > 0) ? 256 : 0;
        v += (outq.size() == DEPTH) ? 512 : 0;
        v += uf ? 1024 : 0;
        v += of ? 2048 : 0;
        v += inq.size() * 4096;
        return 32'(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_cpu_data_in", cpu_data_in, exp_status());
        check("model_s_ready", {31'b0, s_ready},
              {31'b0, inq.size() < DEPTH && !(lb_active() && outq.size() > 0)});
        check("model_m_valid", {31'b0, m_valid}, {31'b0, outq.size() > 0 && !lb_active()});
        check("model_m_data", {24'b0, m_data}, {24'b0, (outq.size() > 0) ? outq[0] : 8'h00});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_valid = 0; cpu_in_rd = 0; cpu_out_wr = 0; err_clr = 0;
    endtask

    initial begin
        // 1: reset values, single host byte, single CPU read
        tick(); tick();
        check("reset_status", cpu_data_in, 32'h0);
        check("reset_s_ready", {31'b0, s_ready}, 32'h1);
        check("reset_m_valid", {31'b0, m_valid}, 32'h0);
        check("reset_m_data", {24'b0, m_data}, 32'h0);
        rst = 1;
        tick();
        s_valid = 1; s_data = 8'hA5; tick(); idle();
        check("push_a5", cpu_data_in, 32'h0000_11A5);
        cpu_in_rd = 1; tick(); idle();
        check("pop_a5", cpu_data_in, 32'h0);

        // 2: fill input FIFO, hold 9th byte, drain in order, wrap
        for (int i = 1; i <= 8; i++) begin
            s_valid = 1; s_data = 8'(i); tick();
        end
        check("in_full_ready", {31'b0, s_ready}, 32'h0);
        check("in_full_status", cpu_data_in, 32'h0000_8101);
        s_data = 8'h09; tick(); idle();
        check("in_hold_9th", cpu_data_in, 32'h0000_8101);
        for (int i = 1; i <= 8; i++) begin
            check("in_order", {24'b0, cpu_data_in[7:0]}, 32'(i));
            cpu_in_rd = 1; tick(); idle();
        end
        check("in_drained", cpu_data_in, 32'h0);
        s_valid = 1; s_data = 8'h09; tick(); idle();
        check("in_wrap", cpu_data_in, 32'h0000_1109);
        cpu_in_rd = 1; tick(); idle();

        // 3: underflow sticky and clear priority
        cpu_in_rd = 1; tick(); idle();
        check("underflow", cpu_data_in, 32'h0000_0400);
        err_clr = 1; tick(); idle();
        check("uf_cleared", cpu_data_in, 32'h0);
        cpu_in_rd = 1; err_clr = 1; tick(); idle();
        check("uf_set_wins", cpu_data_in, 32'h0000_0400);
        err_clr = 1; tick(); idle();

        // 4: output stream
        cpu_out_wr = 1; cpu_data_out = 8'h3C; tick();
        cpu_data_out = 8'hC3; tick(); idle();
        check("out_valid", {31'b0, m_valid}, 32'h1);
        check("out_head_3c", {24'b0, m_data}, 32'h3C);
        m_ready = 1; tick();
        check("out_head_c3", {24'b0, m_data}, 32'hC3);
        tick();
        check("out_empty", {31'b0, m_valid}, 32'h0);
        check("out_empty_data", {24'b0, m_data}, 32'h0);
        m_ready = 0;

        // 5: output overflow, then write-through-full with a pop
        for (int i = 0; i < 8; i++) begin
            cpu_out_wr = 1; cpu_data_out = 8'(8'h10 + i); tick();
        end
        idle();
        check("out_full", cpu_data_in, 32'h0000_0200);
        cpu_out_wr = 1; cpu_data_out = 8'hFF; tick(); idle();
        check("out_overflow", cpu_data_in, 32'h0000_0A00);
        err_clr = 1; tick(); idle();
        cpu_out_wr = 1; cpu_data_out = 8'hFF; m_ready = 1; tick(); idle(); m_ready = 0;
        check("out_full_pop_write", cpu_data_in, 32'h0000_0200);
        check("out_head_after_pop", {24'b0, m_data}, 32'h11);
        m_ready = 1;
        for (int i = 0; i < 8; i++) tick();
        check("out_drained", {31'b0, m_valid}, 32'h0);
        m_ready = 0;

        // 6: asynchronous reset with data in both FIFOs
        for (int i = 0; i < 3; i++) begin
            s_valid = 1; s_data = 8'(8'h40 + i);
            cpu_out_wr = 1; cpu_data_out = 8'(8'h50 + i);
            tick();
        end
        idle();
        check("pre_reset_status", cpu_data_in, 32'h0000_3140);
        #2 rst = 0;
        #1;
        check("async_status", cpu_data_in, 32'h0);
        check("async_m_valid", {31'b0, m_valid}, 32'h0);
        check("async_m_data", {24'b0, m_data}, 32'h0);
        check("async_s_ready", {31'b0, s_ready}, 32'h1);
        tick();
        rst = 1;
        tick();

`ifdef IO_LOOPBACK_EN
        lb_en = 1;
        cpu_out_wr = 1; cpu_data_out = 8'h5A; tick(); idle();
        check("lb_m_valid", {31'b0, m_valid}, 32'h0);
        tick();
        check("lb_byte", {24'b0, cpu_data_in[7:0]}, 32'h5A);
        check("lb_m_valid2", {31'b0, m_valid}, 32'h0);
        lb_en = 0;
        cpu_in_rd = 1; tick(); idle();
`endif
        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_io_bridge.md
Name: cpu_io_bridge

Overview:
- Device-side endpoint of the CPU's byte port interface.
- Accepts host bytes into an input FIFO and presents the head byte plus status to the CPU on its 32-bit data input.
- Captures bytes from the CPU's OUT instructions into an output FIFO and drains them to the host over a valid/ready stream.
- Sits between the CPU core and the testbench/host; the CPU core pulses rd/wr strobes in its EXEC state.

Parameters:
DEPTH, 8, entries per FIFO; power of two, 2..8.
AW, 3, FIFO pointer width = log2(DEPTH).

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset; rst=0 clears all state immediately
s_data  in  8  host byte toward CPU
s_valid  in  1  host byte valid
s_ready  out  1  input FIFO can accept (= !in_full)
cpu_data_in  out  32  to CPU data_in: status and head byte
cpu_in_rd  in  1  CPU IN executed: pop input FIFO (1-cycle pulse)
cpu_data_out  in  8  CPU output register value
cpu_out_wr  in  1  CPU OUT executed: push cpu_data_out (1-cycle pulse)
m_data  out  8  output FIFO head byte
m_valid  out  1  output FIFO non-empty
m_ready  in  1  host accepts m_data
err_clr  in  1  clears sticky error bits

Behaviour:
- Reset values:
  - Both FIFOs empty; all pointers/counts 0; sticky errors 0.
  - cpu_data_in=32'h0, m_valid=0, m_data=8'h00, s_ready=1.
  - Reset mid-transfer discards all FIFO contents.
- FIFOs: circular storage with rd/wr pointers of AW bits (wrap DEPTH-1 -> 0) and count of AW+1 bits.
- Input FIFO:
  - Push when s_valid & s_ready; s_ready=0 when count==DEPTH.
  - Pop on cpu_in_rd when non-empty.
  - Push and pop in the same cycle: both happen, count unchanged.
  - cpu_in_rd when empty: no pointer change; sets sticky in_underflow. This also applies when a push lands in that same cycle, because the pop is evaluated against the pre-edge state.
- cpu_data_in (combinational from registered state):
  - [7:0] head byte, or 8'h00 if empty.
  - [8] in_nonempty.
  - [9] out_full.
  - [10] in_underflow (sticky).
  - [11] out_overflow (sticky).
  - [15:12] input count.
  - [31:16] zero.
  - The head byte is visible in the same cycle the count becomes non-zero, i.e. one cycle after the push edge.
- Output FIFO:
  - Push cpu_data_out on cpu_out_wr.
  - Pop when m_valid & m_ready; m_data = head (8'h00 when empty).
  - cpu_out_wr while full with no pop that cycle: byte dropped, sticky out_overflow set.
  - cpu_out_wr while full with a pop that cycle: write accepted, count stays DEPTH.
- Sticky bits: set has priority over err_clr in the same cycle; err_clr alone clears both bits at the next edge.
- No internal FSM beyond the FIFO pointers. Each side has two conditions, EMPTY and NONEMPTY; FULL is the subset count==DEPTH.
- Latency: host byte to CPU-visible takes 1 cycle; CPU OUT to m_valid takes 1 cycle.

Optional Feature:
IO_LOOPBACK_EN:
- When defined, adds input port lb_en (1 bit).
- With lb_en=1:
  - Output FIFO head is popped into the input FIFO whenever out is non-empty and the input FIFO is not full.
  - This loopback push takes precedence over the host: s_ready=0 that cycle.
  - m_valid is forced 0.
- With lb_en=0, or when the macro is undefined: behaviour is exactly as above.
- When the macro is undefined, the lb_en port does not exist.

Test Plan:
1. Reset then host pushes 8'hA5 -> next cycle cpu_data_in=32'h0000_11A5 (count 1, nonempty); one cpu_in_rd pulse -> cpu_data_in=32'h0.
2. Host pushes 8 bytes 01..08 with DEPTH=8 -> s_ready=0 after 8th; 9th byte 09 held; pops return 01..08 in order, then pointer wrap verified with 09 after next push.
3. cpu_in_rd on empty FIFO -> bit[10]=1 (cpu_data_in=32'h0000_0400); err_clr pulse -> 32'h0; err_clr together with a new underflow -> bit stays 1.
4. CPU writes 8'h3C, 8'hC3 with m_ready=0 -> m_valid=1, m_data=3C; m_ready=1 -> 3C then C3 on consecutive cycles, m_valid=0 after.
5. Fill output FIFO (8 writes, m_ready=0), 9th write 8'hFF -> dropped, bit[11]=1, bit[9]=1; repeat 9th write with m_ready=1 same cycle -> accepted, no overflow.
6. rst=0 asserted asynchronously with 3 bytes in each FIFO -> all outputs at reset values before next clk edge; IO_LOOPBACK_EN build, lb_en=1, CPU writes 8'h5A -> cpu_data_in[7:0]=5A two cycles later, m_valid stays 0.
